fifo_pop_stage: RTL and testbench

Downstream consumer stage for the FIFO memory block. It drains words from the FIFO whenever the FIFO is non-empty and has room locally, and holds them in a 2-entry skid buffer. It presents them as a valid/ready stream with packet framing (`m_last` every `PKT_BEATS` words) and keeps a saturating count of words popped. It connects to the FIFO's read request, read data and empty indicator, and decouples downstream backpressure from the FIFO read path.

---
 rtl/fifo_pop_stage_if.sv | 32 +++
 rtl/fifo_pop_stage.sv | 110 +++++++++++
 tb/tb_fifo_pop_stage.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pop_stage_if.sv
// rtl/fifo_pop_stage_if.sv - FIFO read side and output stream bundle for fifo_pop_stage
interface fifo_pop_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_req;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    input  m_ready,
    output fifo_rd_req,
    output m_valid,
    output m_data,
    output m_last
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    output m_ready,
    input  fifo_rd_req,
    input  m_valid,
    input  m_data,
    input  m_last
  );
endinterface

// File: rtl/fifo_pop_stage.sv
// rtl/fifo_pop_stage.sv - FIFO drain stage with 2-entry skid buffer, packet framing and pop counter
module fifo_pop_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_BEATS  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk_in,
  input  logic                 areset_b,
  input  logic                 flush,
  fifo_pop_stage_if.master     bus,
  output logic [CNT_WIDTH-1:0] pop_count
);
  localparam int BEAT_W = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_BEATS - 1);

  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic                  head_last_q, head_last_d;
  logic [DATA_WIDTH-1:0] tail_data_q, tail_data_d;
  logic                  tail_last_q, tail_last_d;
  logic [1:0]            occ_q, occ_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  pop_count_q, pop_count_d;

  logic pop;
  logic acc;
  logic new_last;

  always_comb begin
    // A full buffer may still pop when the head leaves in the same cycle
    pop      = ~flush & ~bus.fifo_empty & ((occ_q != 2'd2) | bus.m_ready);
    acc      = (occ_q != 2'd0) & bus.m_ready;
    new_last = (beat_q == LAST_BEAT);

    head_data_d = head_data_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_last_d = tail_last_q;
    occ_d       = occ_q;
    beat_d      = beat_q;
    pop_count_d = pop_count_q;

    if (pop && !(&pop_count_q)) begin
      pop_count_d = pop_count_q + CNT_WIDTH'(1);
    end

    if (flush) begin
      occ_d  = 2'd0;
      beat_d = '0;
    end else begin
      if (pop) begin
        beat_d = new_last ? '0 : beat_q + BEAT_W'(1);
      end
      case ({pop, acc})
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_data_d = bus.fifo_rd_data;
            head_last_d = new_last;
          end else begin
            tail_data_d = bus.fifo_rd_data;
            tail_last_d = new_last;
          end
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          head_data_d = tail_data_q;
          head_last_d = tail_last_q;
          occ_d       = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_data_d = bus.fifo_rd_data;
            head_last_d = new_last;
          end else begin
            head_data_d = tail_data_q;
            head_last_d = tail_last_q;
            tail_data_d = bus.fifo_rd_data;
            tail_last_d = new_last;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      head_data_q <= '0;
      head_last_q <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
      occ_q       <= 2'd0;
      beat_q      <= '0;
      pop_count_q <= '0;
    end else begin
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      tail_data_q <= tail_data_d;
      tail_last_q <= tail_last_d;
      occ_q       <= occ_d;
      beat_q      <= beat_d;
      pop_count_q <= pop_count_d;
    end
  end

  assign bus.fifo_rd_req = pop;
  assign bus.m_valid     = (occ_q != 2'd0);
  assign bus.m_data      = head_data_q;
  assign bus.m_last      = head_last_q;
  assign pop_count       = pop_count_q;
endmodule

// File: tb/tb_fifo_pop_stage.sv
// tb/tb_fifo_pop_stage.sv - self-checking bench for fifo_pop_stage
module tb_fifo_pop_stage;
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic areset_b, flush, m_ready, force_empty;
  logic [31:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic fifo_empty;
  logic [31:0] fifo_rd_data;
  assign fifo_empty   = force_empty | (rd_ptr == wr_ptr);
  assign fifo_rd_data = mem[rd_ptr[7:0]];

  fifo_pop_stage_if #(.DATA_WIDTH(32)) ifc0 ();
  fifo_pop_stage_if #(.DATA_WIDTH(32)) ifc1 ();
  fifo_pop_stage_if #(.DATA_WIDTH(32)) ifc2 ();
  assign ifc0.fifo_empty = fifo_empty;  assign ifc0.fifo_rd_data = fifo_rd_data;  assign ifc0.m_ready = m_ready;
  assign ifc1.fifo_empty = fifo_empty;  assign ifc1.fifo_rd_data = fifo_rd_data;  assign ifc1.m_ready = m_ready;
  assign ifc2.fifo_empty = fifo_empty;  assign ifc2.fifo_rd_data = fifo_rd_data;  assign ifc2.m_ready = m_ready;

  logic [15:0] cnt0, cnt1;
  logic [2:0]  cnt2;

  fifo_pop_stage #(.DATA_WIDTH(32), .PKT_BEATS(4), .CNT_WIDTH(16)) u_dut0 (
    .clk_in(clk_in), .areset_b(areset_b), .flush(flush), .bus(ifc0), .pop_count(cnt0));
  fifo_pop_stage #(.DATA_WIDTH(32), .PKT_BEATS(1), .CNT_WIDTH(16)) u_dut1 (
    .clk_in(clk_in), .areset_b(areset_b), .flush(flush), .bus(ifc1), .pop_count(cnt1));
  fifo_pop_stage #(.DATA_WIDTH(32), .PKT_BEATS(3), .CNT_WIDTH(3)) u_dut2 (
    .clk_in(clk_in), .areset_b(areset_b), .flush(flush), .bus(ifc2), .pop_count(cnt2));

  always @(posedge clk_in) if (ifc0.fifo_rd_req) rd_ptr <= rd_ptr + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard entry: {data, last@PKT_BEATS=4, last@PKT_BEATS=1, last@PKT_BEATS=3}
  logic [34:0] sb [$];
  int beat_n    = 0;
  int total_pop = 0;
  int total_acc = 0;

  always @(negedge clk_in) begin
    logic [34:0] e;
    if (!areset_b) begin
      sb.delete();
      beat_n = 0;
    end else begin
      check("req_match_1", ifc1.fifo_rd_req, ifc0.fifo_rd_req);
      check("req_match_2", ifc2.fifo_rd_req, ifc0.fifo_rd_req);
      if (fifo_empty) check("req_while_empty", ifc0.fifo_rd_req, 1'b0);
      if (ifc0.m_valid && m_ready) begin
        total_acc++;
        check("sb_nonempty", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("data0", ifc0.m_data, e[34:3]);
          check("data2", ifc2.m_data, e[34:3]);
          check("last_p4", ifc0.m_last, e[2]);
          check("last_p1", ifc1.m_last, e[1]);
          check("last_p3", ifc2.m_last, e[0]);
        end
      end
      if (flush) begin
        sb.delete();
        beat_n = 0;
      end else if (ifc0.fifo_rd_req) begin
        sb.push_back({mem[rd_ptr[7:0]], (beat_n % 4 == 3), 1'b1, (beat_n % 3 == 2)});
        beat_n++;
        total_pop++;
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    mem[wr_ptr[7:0]] = v;
    wr_ptr++;
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((sb.size() != 0 || rd_ptr != wr_ptr) && k < 200) begin
      tick();
      k++;
    end
    check("drain_timeout", (k >= 200), 1'b0);
  endtask

  initial begin
    int p0, a0;
    logic [15:0] c;
    areset_b = 1'b0; flush = 1'b0; m_ready = 1'b0; force_empty = 1'b1;
    repeat (2) tick();
    check("rst_valid", ifc0.m_valid, 1'b0);
    check("rst_data", ifc0.m_data, 32'h0);
    check("rst_last", ifc0.m_last, 1'b0);
    check("rst_cnt0", cnt0, 16'h0);
    check("rst_cnt2", cnt2, 3'h0);
    areset_b = 1'b1;
    tick();

    // Four words, downstream always ready
    for (int i = 1; i <= 4; i++) push(32'hAAAA_0000 + i);
    m_ready = 1'b1; force_empty = 1'b0; a0 = total_acc;
    #1 check("t1_req", ifc0.fifo_rd_req, 1'b1);
    tick();
    check("t1_lat_valid", ifc0.m_valid, 1'b1);
    check("t1_lat_data", ifc0.m_data, 32'hAAAA_0001);
    repeat (4) tick();
    check("t1_accepts", total_acc - a0, 4);
    check("t1_idle", ifc0.m_valid, 1'b0);
    check("t1_cnt0", cnt0, 16'd4);
    check("t1_cnt2", cnt2, 3'd4);

    // Backpressure: five words, only two may be popped
    m_ready = 1'b0; p0 = total_pop;
    for (int i = 0; i < 5; i++) push(32'hBBBB_0000 + i);
    repeat (6) tick();
    check("t2_pops", total_pop - p0, 2);
    check("t2_req_off", ifc0.fifo_rd_req, 1'b0);
    check("t2_valid_hold", ifc0.m_valid, 1'b1);
    check("t2_data_hold", ifc0.m_data, 32'hBBBB_0000);
    m_ready = 1'b1; a0 = total_acc;
    repeat (5) tick();
    check("t2_no_gap", total_acc - a0, 5);
    check("t2_idle", ifc0.m_valid, 1'b0);

    // FIFO empty toggling every cycle
    p0 = total_pop; a0 = total_acc;
    for (int i = 0; i < 8; i++) push(32'hCCCC_0000 + i);
    for (int i = 0; i < 12; i++) begin
      force_empty = ~force_empty;
      tick();
    end
    force_empty = 1'b0;
    wait_drain();
    tick();
    check("t3_pops", total_pop - p0, 8);
    check("t3_accepts", total_acc - a0, 8);

    // Flush with a full buffer two beats into a packet
    flush = 1'b1;
    tick();
    flush = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'hDDDD_0000 + i);
    repeat (4) tick();
    check("t4_full", ifc0.fifo_rd_req, 1'b0);
    c = cnt0;
    flush = 1'b1; m_ready = 1'b1;
    #1 check("t4_req_in_flush", ifc0.fifo_rd_req, 1'b0);
    tick();
    check("t4_valid_cleared", ifc0.m_valid, 1'b0);
    check("t4_cnt_kept", cnt0, c);
    flush = 1'b0;
    tick();
    check("t4_next_valid", ifc0.m_valid, 1'b1);
    check("t4_next_data", ifc0.m_data, 32'hDDDD_0002);
    check("t4_beat0_last", ifc0.m_last, 1'b0);
    check("t4_p1_last", ifc1.m_last, 1'b1);
    wait_drain();
    tick();

    // Reset mid-stream, then 7-word run for the 3-beat packet and 3-bit counter
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(32'hEEEE_0000 + i);
    repeat (3) tick();
    force_empty = 1'b1;
    areset_b = 1'b0;
    #1;
    check("t5_rst_valid", ifc0.m_valid, 1'b0);
    check("t5_rst_data", ifc0.m_data, 32'h0);
    check("t5_rst_last", ifc0.m_last, 1'b0);
    check("t5_rst_cnt0", cnt0, 16'h0);
    check("t5_rst_cnt2", cnt2, 3'h0);
    tick();
    areset_b = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) push(32'hF0F0_0000 + i);
    m_ready = 1'b1; force_empty = 1'b0;
    wait_drain();
    tick();
    check("t5_cnt0_7", cnt0, 16'd7);
    check("t5_cnt2_7", cnt2, 3'd7);
    for (int i = 0; i < 3; i++) push(32'h5A5A_0000 + i);
    wait_drain();
    tick();
    check("t5_cnt0_10", cnt0, 16'd10);
    check("t5_cnt2_sat", cnt2, 3'd7);
    check("t5_cnt1_10", cnt1, 16'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
